// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver. Double-flop synchronises the serial line,
// validates the start bit at mid-bit, samples eight data bits LSB first at
// mid-bit and checks the stop bit. Emits a one-cycle valid strobe with the
// byte, or a one-cycle frame_err strobe, and then waits for the line to
// return high after a framing error so a held-low break is not decoded as
// repeated 0x00 frames.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_t;

  state_t        state_q, state_d;
  logic          s1_q, s2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          rx_s;

  assign rx_s = s2_q;

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= rx;
      s2_q <= s1_q;
    end
  end

  // State, counters, shift register and registered output strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state logic: mid-bit sampling driven by the cycle counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end

      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = DATA;
            bit_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shreg_d = {rx_s, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BRK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      BRK: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx. The driver issues serial frames
// and pushes the expected event (byte or framing error, plus the cycle it
// must appear in) into a queue; a monitor pops and compares on every strobe.
module tb_uart_rx;

  localparam int C = 16;
  localparam int H = C / 2;
  localparam int unsigned LAT = 3 + H + 9 * C;  // start drop -> strobe cycle

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [7:0]  d;
    int unsigned cyc;
  } ev_t;

  ev_t         sb[$];
  int unsigned cyc = 0;
  int          errors = 0;
  int          nchecks = 0;
  logic [7:0]  exp_data = 8'h00;
  bit          mon_en = 1'b0;
  bit          prev_busy = 1'b0;
  int unsigned rise_cyc = 0;
  int unsigned fall_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    nchecks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: sampled 1 time unit after each active edge.
  always @(posedge clk) begin
    ev_t e;
    #1;
    if (mon_en) begin
      if (busy && !prev_busy) rise_cyc = cyc;
      if (!busy && prev_busy) fall_cyc = cyc;
      prev_busy = busy;
      if (valid && frame_err) check("valid_and_ferr", 1, 0);
      if (valid || frame_err) begin
        if (sb.size() == 0) begin
          check("unexpected_strobe", {valid, frame_err}, 0);
        end else begin
          e = sb.pop_front();
          check("strobe_kind", frame_err, e.is_err);
          check("strobe_cycle", cyc, e.cyc);
          if (!e.is_err) exp_data = e.d;
          check("data_on_strobe", data, exp_data);
        end
      end else begin
        check("data_hold", data, exp_data);
      end
    end
  end

  // Drive one frame starting at the current negedge; stop_bit=0 forces a framing error.
  task automatic send_frame(input logic [7:0] b, input bit stop_bit, output int unsigned start);
    ev_t e;
    start = cyc;
    e.is_err = !stop_bit;
    e.d      = b;
    e.cyc    = start + LAT;
    sb.push_back(e);
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (C) @(negedge clk);
    end
    rx = stop_bit;
    repeat (C) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic glitch(input int len, output int unsigned start);
    start = cyc;
    rx = 1'b0;
    repeat (len) @(negedge clk);
    rx = 1'b1;
  endtask

  initial begin
    int unsigned st;
    logic [7:0]  b;
    int          k;

    // Reset / idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_valid", valid, 0);
      check("idle_ferr", frame_err, 0);
    end

    // Single byte
    send_frame(8'h5A, 1'b1, st);
    idle(20);
    check("busy_rise_cycle", rise_cyc, st + 3);
    check("data_5A", data, 8'h5A);

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1, st);
    send_frame(8'hFF, 1'b1, st);
    send_frame(8'h2B, 1'b1, st);
    send_frame(8'h81, 1'b1, st);
    idle(20);
    check("data_81", data, 8'h81);

    // Glitch on the start bit
    glitch(4, st);
    idle(30);
    check("glitch_rise", rise_cyc, st + 3);
    check("glitch_busy_len", fall_cyc - rise_cyc, 8);
    check("glitch_data", data, 8'h81);

    // Framing error followed by a long break, then a good frame
    send_frame(8'h13, 1'b0, st);
    rx = 1'b0;
    repeat (100) @(negedge clk);
    check("break_busy", busy, 1);
    idle(20);
    check("after_break_busy", busy, 0);
    check("ferr_data_held", data, 8'h81);
    send_frame(8'h7D, 1'b1, st);
    idle(20);
    check("data_7D", data, 8'h7D);

    // Reset in the middle of bit 4 of 8'hAB
    b = 8'hAB;
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (C) @(negedge clk);
    end
    rx = b[4];
    repeat (H) @(negedge clk);
    rst = 1'b1;
    exp_data = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    rx = 1'b1;
    repeat (5) @(negedge clk);
    check("post_reset_busy", busy, 0);
    check("post_reset_data", data, 8'h00);
    idle(C * 6);
    send_frame(8'h51, 1'b1, st);
    idle(20);
    check("data_51", data, 8'h51);

    // Randomised mix of good frames, framing errors and glitches
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 7);
      if (k == 0) begin
        glitch($urandom_range(1, 6), st);
        idle(14 + $urandom_range(0, 10));
      end else if (k == 1) begin
        send_frame(8'($urandom), 1'b0, st);
        rx = 1'b0;
        repeat ($urandom_range(0, 40)) @(negedge clk);
        idle(4 + $urandom_range(0, 10));
      end else begin
        send_frame(8'($urandom), 1'b1, st);
        idle($urandom_range(0, 20));
      end
    end

    // Drain: every expected event must have appeared.
    for (int i = 0; i < 1000 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    idle(10);
    check("final_idle_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, nchecks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart of the UART_TX transmitter.
- Samples the asynchronous serial line `rx` on a clock at CLKS_PER_BIT × baud rate.
- Validates the start bit, samples each data bit at mid-bit and checks the stop bit.
- Delivers each byte with a one-cycle valid strobe, or reports a framing error.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per serial bit. Must be even and ≥4. Half-bit count H = CLKS_PER_BIT/2.

Ports:
- clk  input  1  system clock, CLKS_PER_BIT × baud.
- rst  input  1  synchronous reset, active-high (one clock; reset is synchronous and active-high).
- rx  input  1  asynchronous serial line; idles high; LSB first.
- data  output  8  last correctly received byte; held until the next good frame.
- valid  output  1  one-cycle pulse when `data` updates.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- busy  output  1  high whenever FSM ≠ IDLE.

Behaviour:
- Reset (rst=1 at posedge clk):
  - state=IDLE; sync flops=1; bit counter=0; cycle counter=0; shift reg=0.
  - data=8'h00, valid=0, frame_err=0, busy=0.
  - Reset mid-frame abandons the frame with no valid/frame_err pulse.
- Synchronizer: rx → s1 → s2 (rx_s); FSM uses rx_s only.
- Counters: cycle counter cnt width ceil(log2(CLKS_PER_BIT)); bit index 0..7.
- IDLE:
  - rx_s=0 → START, cnt=0.
  - Otherwise stay.
- START: cnt increments each clock. At cnt=H-1 (mid start bit):
  - rx_s=0 → DATA, cnt=0, bit_idx=0.
  - rx_s=1 → IDLE (glitch rejected; no outputs pulse).
- DATA: cnt increments each clock. At cnt=CLKS_PER_BIT-1:
  - Shift right: shreg <= {rx_s, shreg[7:1]}; cnt=0; bit_idx++.
  - After the 8th sample (bit_idx=7) → STOP.
- STOP: at cnt=CLKS_PER_BIT-1, sample rx_s.
  - rx_s=1 → data<=shreg, valid=1 for one cycle, → IDLE.
  - rx_s=0 → frame_err=1 for one cycle, data unchanged, → BREAK.
- BREAK: wait for rx_s=1, then → IDLE. Prevents a held-low line (break) from being decoded as repeated 0x00 frames.
- valid and frame_err are registered, never high together, and never high for more than one cycle.
- Latency (edge 0 = first posedge sampling rx low): rx_s low seen at edge 2; START entered at edge 3; valid high in the cycle after edge 3+H+9·CLKS_PER_BIT. For default 16: edge 155.
- Back-to-back frames: IDLE is re-entered at the mid stop bit. A start edge immediately following the stop bit is detected with no lost frame.
- No downstream handshake: consumer must capture data on valid. A new good frame overwrites data (no overrun flag).
- Line idle-high with no activity: outputs remain at reset values indefinitely.

Test Plan:
- Reset/idle: rst high 3 cycles, rx=1 for 500 cycles → data=8'h00, valid=0, frame_err=0, busy=0 throughout.
- Single byte 8'h5A at 16 clk/bit, start edge at edge 0 → busy rises at edge 3; exactly one valid pulse in the cycle after edge 155; data=8'h5A; frame_err never high.
- Back-to-back frames 8'h00, 8'hFF, 8'h2B, 8'h81 with no idle gap → four valid pulses 160 cycles apart; data matches each byte in order.
- Glitch: rx low for 4 cycles, then high → busy high 8 cycles then IDLE; no valid, no frame_err.
- Framing error: frame 8'h13 with stop bit forced 0, line held low 100 more cycles, then high, then frame 8'h7D → one frame_err pulse; data stays at its prior value; no spurious frames during the low period; then valid with data=8'h7D.
- Reset mid-frame: assert rst during bit 4 of 8'hAB, release, then send 8'h51 → no pulse for 8'hAB; valid with data=8'h51.
